// File: rtl/mem_load_pkg.sv
// Shared load-path definitions: funct3 load encodings, load FSM state codes,
// AXI response codes and the latched per-load control bundle.
package mem_load_pkg;

  // funct3 encodings for RV32I loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // load FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // AXI read response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // control fields captured when a load is accepted
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] off;
  } ld_ctl_t;

endpackage

// File: rtl/mem_load_if.sv
// AXI4-Lite-style read channel between the load unit (master) and memory.
// MEM_LOAD_BUS_ERR_EN adds the MEM_RRESP response field.
interface mem_load_if;
  logic        MEM_ARVALID;
  logic        MEM_ARREADY;
  logic [31:0] MEM_ARADDR;
  logic        MEM_RVALID;
  logic        MEM_RREADY;
  logic [31:0] MEM_RDATA;
`ifdef MEM_LOAD_BUS_ERR_EN
  logic [1:0]  MEM_RRESP;
`endif

  modport master (
    output MEM_ARVALID, MEM_ARADDR, MEM_RREADY,
`ifdef MEM_LOAD_BUS_ERR_EN
    input  MEM_RRESP,
`endif
    input  MEM_ARREADY, MEM_RVALID, MEM_RDATA
  );

  modport slave (
    input  MEM_ARVALID, MEM_ARADDR, MEM_RREADY,
`ifdef MEM_LOAD_BUS_ERR_EN
    output MEM_RRESP,
`endif
    output MEM_ARREADY, MEM_RVALID, MEM_RDATA
  );
endinterface

// File: rtl/mem_load_align.sv
// load_align: combinational byte/halfword extraction and sign/zero extension
// of a 32-bit bus word, plus the exception flag (misaligned half/word access
// or a funct3 that is not a load). Shared with the store path.
module load_align
  import mem_load_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  b;
  logic [15:0] h;

  // select lane by offset, then extend according to funct3
  always_comb begin
    b = '0;
    case (off)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = '0;
    endcase
    h        = off[1] ? word[31:16] : word[15:0];
    data     = '0;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{b[7]}}, b};
      F3_LBU: data = {24'h0, b};
      F3_LH:  begin data = {{16{h[15]}}, h}; misalign = off[0]; end
      F3_LHU: begin data = {16'h0, h};       misalign = off[0]; end
      F3_LW:  begin data = word;             misalign = (off != 2'd0); end
      default: misalign = 1'b1;  // 011/110/111 are not loads
    endcase
  end

endmodule

// File: rtl/mem_load.sv
// mem_load: single-outstanding data-side load unit between execute and
// mem_rd. Stalls the pipe while a bus read is in flight and presents the
// formatted result in DONE.
// Optional feature macro: MEM_LOAD_BUS_ERR_EN (read response error -> LOAD_EXC).
module mem_load
  import mem_load_pkg::*;
#(
  parameter bit BUS_WORD_ADDR = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        A_VALID,
  input  logic        A_LOAD_EN,
  input  logic [31:0] A_LOAD_ADDR,
  input  logic [2:0]  A_LOAD_FUNCT3,
  mem_load_if.master  bus,
  output logic        STALL_REQ,
  output logic        DATA_RDVALID,
  output logic [31:0] DATA_RDDATA,
  output logic        LOAD_EXC
);

  logic [1:0]  state;
  ld_ctl_t     ctl_q;
  logic [31:0] araddr_q;
  logic [31:0] data_q;
  logic        exc_q;
  logic        kill_q;

  logic        accept;
  logic        resp_err;
  logic        in_data;
  logic [2:0]  al_funct3;
  logic [1:0]  al_off;
  logic [31:0] al_data;
  logic        al_misalign;

  assign accept = ((state == ST_IDLE) || (state == ST_DONE)) &&
                  !STALL && !FLUSH && A_VALID && A_LOAD_EN;

`ifdef MEM_LOAD_BUS_ERR_EN
  assign resp_err = (bus.MEM_RRESP != RESP_OKAY);
`else
  assign resp_err = 1'b0;
`endif

  // One aligner serves both jobs: while waiting for data it formats the
  // returned word with the latched control; otherwise it screens the
  // incoming request for exceptions.
  assign in_data   = (state == ST_DATA);
  assign al_funct3 = in_data ? ctl_q.funct3 : A_LOAD_FUNCT3;
  assign al_off    = in_data ? ctl_q.off    : A_LOAD_ADDR[1:0];

  load_align u_align (
    .funct3   (al_funct3),
    .off      (al_off),
    .word     (bus.MEM_RDATA),
    .data     (al_data),
    .misalign (al_misalign)
  );

  // load FSM: accept, address phase, data phase, result hold
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      ctl_q    <= '0;
      araddr_q <= '0;
      data_q   <= '0;
      exc_q    <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            ctl_q.funct3 <= A_LOAD_FUNCT3;
            ctl_q.off    <= A_LOAD_ADDR[1:0];
            araddr_q     <= BUS_WORD_ADDR ? {A_LOAD_ADDR[31:2], 2'b00} : A_LOAD_ADDR;
            kill_q       <= 1'b0;
            data_q       <= '0;
            if (al_misalign) begin
              // no bus traffic for a faulting load; report it directly
              state <= ST_DONE;
              exc_q <= 1'b1;
            end else begin
              state <= ST_ADDR;
              exc_q <= 1'b0;
            end
          end else if ((state == ST_DONE) && (FLUSH || !STALL)) begin
            state <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (FLUSH) kill_q <= 1'b1;
          if (bus.MEM_ARREADY) state <= ST_DATA;
        end
        ST_DATA: begin
          if (FLUSH) kill_q <= 1'b1;
          if (bus.MEM_RVALID) begin
            // a flushed load still drains its response, then vanishes
            state  <= (kill_q || FLUSH) ? ST_IDLE : ST_DONE;
            data_q <= resp_err ? 32'h0 : al_data;
            exc_q  <= resp_err;
            kill_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.MEM_ARVALID = (state == ST_ADDR);
  assign bus.MEM_ARADDR  = araddr_q;
  assign bus.MEM_RREADY  = (state == ST_DATA);
  assign STALL_REQ       = (state == ST_ADDR) || (state == ST_DATA);
  assign DATA_RDVALID    = (state == ST_DONE);
  assign DATA_RDDATA     = (state == ST_DONE) ? data_q : 32'h0;
  assign LOAD_EXC        = (state == ST_DONE) && exc_q;

endmodule

// File: tb/tb_mem_load.sv
// Self-checking bench for mem_load: transaction-level reference model,
// per-cycle compare, directed cases with literal expectations, random run.
module tb_mem_load;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, a_valid = 1'b0, a_load_en = 1'b0;
  logic [31:0] a_addr = '0;
  logic [2:0]  a_f3 = '0;
  logic        stall_req, rdvalid, load_exc;
  logic [31:0] rddata;

  always #5 clk = ~clk;

  mem_load_if bus();

  mem_load #(.BUS_WORD_ADDR(1'b1)) dut (
    .CLK(clk), .RST(rst), .STALL(stall), .FLUSH(flush),
    .A_VALID(a_valid), .A_LOAD_EN(a_load_en),
    .A_LOAD_ADDR(a_addr), .A_LOAD_FUNCT3(a_f3),
    .bus(bus),
    .STALL_REQ(stall_req), .DATA_RDVALID(rdvalid),
    .DATA_RDDATA(rddata), .LOAD_EXC(load_exc)
  );

  int nchk = 0, nerr = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic is_exc(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if ((f3 == 3'b001 || f3 == 3'b101) && off[0]) return 1'b1;
    if (f3 == 3'b010 && off != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // m_pend: a bus read is owed; m_arok: its address was taken;
  // m_rv/m_data/m_exc: result currently offered to mem_rd
  logic        m_pend = 0, m_arok = 0, m_kill = 0, m_rv = 0, m_exc = 0;
  logic [31:0] m_data = '0, m_araddr = '0;
  logic [2:0]  m_f3 = '0;
  logic [1:0]  m_off = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 0; m_arok <= 0; m_kill <= 0; m_rv <= 0; m_exc <= 0;
      m_data <= '0; m_araddr <= '0; m_f3 <= '0; m_off <= '0;
    end else if (m_pend) begin
      if (!m_arok) begin
        if (bus.MEM_ARREADY) m_arok <= 1;
        if (flush) m_kill <= 1;
      end else if (bus.MEM_RVALID) begin
        m_pend <= 0; m_arok <= 0; m_kill <= 0;
        if (!(m_kill || flush)) begin
          m_rv <= 1; m_exc <= 0;
          m_data <= fmt(m_f3, m_off, bus.MEM_RDATA);
        end
      end else if (flush) m_kill <= 1;
    end else if (!stall && !flush && a_valid && a_load_en) begin
      m_f3 <= a_f3; m_off <= a_addr[1:0];
      m_araddr <= {a_addr[31:2], 2'b00};
      if (is_exc(a_f3, a_addr[1:0])) begin
        m_rv <= 1; m_exc <= 1; m_data <= '0;
      end else begin
        m_pend <= 1; m_arok <= 0; m_kill <= 0; m_rv <= 0;
      end
    end else if (flush || !stall) m_rv <= 0;
  end

  // compare every cycle, mid-period
  always @(negedge clk) begin
    check("arvalid", bus.MEM_ARVALID, m_pend && !m_arok);
    if (m_pend && !m_arok) check("araddr", bus.MEM_ARADDR, m_araddr);
    check("rready", bus.MEM_RREADY, m_pend && m_arok);
    check("stall_req", stall_req, m_pend);
    check("rdvalid", rdvalid, m_rv);
    check("rddata", rddata, m_rv ? m_data : 32'h0);
    check("load_exc", load_exc, m_rv && m_exc);
  end

  // ---------------- memory responder ----------------
  logic        rnd_mode = 0, fix_en = 0;
  logic [31:0] fix_word = '0;
  int          ar_dly = 0, r_dly = 0, ar_wait = 0, r_wait = 0;

  initial begin
    bus.MEM_ARREADY = 0; bus.MEM_RVALID = 0; bus.MEM_RDATA = '0;
`ifdef MEM_LOAD_BUS_ERR_EN
    bus.MEM_RRESP = 2'b00;
`endif
  end

  task automatic cycle();
    @(posedge clk); #1;
    if (bus.MEM_ARVALID) begin
      if (rnd_mode) bus.MEM_ARREADY = ($urandom_range(0, 2) == 0);
      else begin
        bus.MEM_ARREADY = (ar_wait >= ar_dly);
        ar_wait = bus.MEM_ARREADY ? 0 : ar_wait + 1;
      end
    end else bus.MEM_ARREADY = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
    if (bus.MEM_RREADY) begin
      if (rnd_mode) bus.MEM_RVALID = ($urandom_range(0, 2) == 0);
      else begin
        bus.MEM_RVALID = (r_wait >= r_dly);
        r_wait = bus.MEM_RVALID ? 0 : r_wait + 1;
      end
    end else bus.MEM_RVALID = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
    bus.MEM_RDATA = (fix_en && !rnd_mode) ? fix_word : $urandom;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] addr);
    a_valid = 1; a_load_en = 1; a_f3 = f3; a_addr = addr;
    cycle();
    a_valid = 0;
  endtask

  task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] word, input int ard, input int rd,
                         input logic [31:0] exp_data, input logic exp_exc, input int exp_stall);
    int n, k;
    logic saw_ar;
    fix_en = 1; fix_word = word; ar_dly = ard; r_dly = rd; ar_wait = 0; r_wait = 0;
    issue(f3, addr);
    n = 0; k = 0; saw_ar = 0;
    while (!rdvalid && k < 60) begin
      if (stall_req) n++;
      if (bus.MEM_ARVALID) saw_ar = 1;
      cycle(); k++;
    end
    check({nm, "_rdvalid"}, rdvalid, 1);
    check({nm, "_data"}, rddata, exp_data);
    check({nm, "_exc"}, load_exc, exp_exc);
    check({nm, "_stall_cycles"}, n, exp_stall);
    if (exp_exc) check({nm, "_no_ar"}, saw_ar, 0);
    cycle();
  endtask

  initial begin
    int k, held;
    logic saw_rv;
    repeat (2) @(posedge clk);
    #1;
    check("rst_arvalid", bus.MEM_ARVALID, 0);
    check("rst_stall_req", stall_req, 0);
    check("rst_rdvalid", rdvalid, 0);
    check("rst_rddata", rddata, 0);
    check("rst_exc", load_exc, 0);
    rst = 0;
    cycle();

    do_load("lw",     3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 2);
    do_load("lb",     3'b000, 32'h103, 32'h80FFFFFF, 0, 0, 32'hFFFFFF80, 0, 2);
    do_load("lbu",    3'b100, 32'h103, 32'h80FFFFFF, 0, 0, 32'h00000080, 0, 2);
    do_load("lhu",    3'b101, 32'h102, 32'h80010000, 0, 0, 32'h00008001, 0, 2);
    do_load("lh",     3'b001, 32'h102, 32'h80010000, 0, 0, 32'hFFFF8001, 0, 2);
    do_load("lw_mis", 3'b010, 32'h102, 32'h12345678, 0, 0, 32'h0, 1, 0);
    do_load("lh_mis", 3'b001, 32'h101, 32'h12345678, 0, 0, 32'h0, 1, 0);
    do_load("f3_bad", 3'b011, 32'h100, 32'h12345678, 0, 0, 32'h0, 1, 0);
    do_load("lw_slow", 3'b010, 32'h104, 32'h12345678, 3, 5, 32'h12345678, 0, 10);

    // flush while waiting for data: response drains, no result
    fix_word = 32'hCAFEF00D; ar_dly = 0; r_dly = 3; ar_wait = 0; r_wait = 0;
    issue(3'b010, 32'h300);
    k = 0;
    while (!bus.MEM_RREADY && k < 20) begin cycle(); k++; end
    check("flush_reach_data", bus.MEM_RREADY, 1);
    flush = 1; cycle(); flush = 0;
    saw_rv = 0; k = 0;
    while (stall_req && k < 30) begin
      if (rdvalid) saw_rv = 1;
      cycle(); k++;
    end
    repeat (3) begin if (rdvalid) saw_rv = 1; cycle(); end
    check("flush_drained", stall_req, 0);
    check("flush_no_rdvalid", saw_rv, 0);
    check("flush_idle_ar", bus.MEM_ARVALID, 0);

    // back-to-back loads with a held result under STALL
    fix_word = 32'hAAAA5555; r_dly = 0;
    issue(3'b010, 32'h200);
    k = 0;
    while (!rdvalid && k < 20) begin cycle(); k++; end
    fix_word = 32'h5A5A0F0F;
    stall = 1; a_valid = 1; a_load_en = 1; a_f3 = 3'b010; a_addr = 32'h204;
    held = 0;
    repeat (2) begin
      if (rdvalid && rddata == 32'hAAAA5555) held++;
      cycle();
    end
    if (rdvalid && rddata == 32'hAAAA5555) held++;
    stall = 0;
    check("b2b_held_cycles", held, 3);
    cycle();
    a_valid = 0;
    check("b2b_ar_next", bus.MEM_ARVALID, 1);
    check("b2b_ar_addr", bus.MEM_ARADDR, 32'h204);
    check("b2b_rv_drop", rdvalid, 0);
    k = 0;
    while (!rdvalid && k < 20) begin cycle(); k++; end
    check("b2b_second_data", rddata, 32'h5A5A0F0F);
    cycle();

    // randomized traffic against the model
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      a_valid   = ($urandom_range(0, 2) != 0);
      a_load_en = ($urandom_range(0, 3) != 0);
      a_f3      = 3'($urandom_range(0, 7));
      a_addr    = $urandom;
      rst       = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 0; stall = 0; flush = 0; a_valid = 0;
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
